// File: rtl/key_conditioner_pkg.sv
// Shared constants for the key conditioner: channel widths, button/switch bit indices,
// default timing and the repeat FSM state encodings.
package key_conditioner_pkg;

  localparam int unsigned NOTE_KEY_BITS   = 7;
  localparam int unsigned LENGTH_KEY_BITS = 7;
  localparam int unsigned BTN_BITS        = 4;
  localparam int unsigned SW_BITS         = 2;
  localparam int unsigned NUM_CHANNELS    = BTN_BITS + NOTE_KEY_BITS + LENGTH_KEY_BITS + SW_BITS;

  localparam int unsigned BTN_SUBMIT   = 0;
  localparam int unsigned BTN_CANCEL   = 1;
  localparam int unsigned BTN_OCT_UP   = 2;
  localparam int unsigned BTN_OCT_DOWN = 3;

  localparam int unsigned SW_RESET = 0;
  localparam int unsigned SW_IS_RW = 1;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 2_000_000;
  localparam int unsigned DEF_REPEAT_DELAY    = 50_000_000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 20_000_000;

  localparam logic [1:0] RPT_IDLE   = 2'd0;
  localparam logic [1:0] RPT_DELAY  = 2'd1;
  localparam logic [1:0] RPT_REPEAT = 2'd2;

  // Key vectors are at most 7 wide, so an 8-bit population count covers both.
  function automatic logic [3:0] count_ones(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/key_conditioner_if.sv
// Raw front-panel inputs and their conditioned outputs; slave is the conditioner's view.
interface key_conditioner_if;
  import key_conditioner_pkg::*;

  logic [BTN_BITS-1:0]        raw_btn;
  logic [NOTE_KEY_BITS-1:0]   raw_note;
  logic [LENGTH_KEY_BITS-1:0] raw_len;
  logic [SW_BITS-1:0]         raw_sw;

  logic [BTN_BITS-1:0]        btn_level;
  logic [BTN_BITS-1:0]        btn_pulse;
  logic [NOTE_KEY_BITS-1:0]   note_onehot;
  logic                       note_multi;
  logic [LENGTH_KEY_BITS-1:0] len_onehot;
  logic [SW_BITS-1:0]         sw_level;

  modport slave (
    input  raw_btn, raw_note, raw_len, raw_sw,
    output btn_level, btn_pulse, note_onehot, note_multi, len_onehot, sw_level
  );

  modport master (
    output raw_btn, raw_note, raw_len, raw_sw,
    input  btn_level, btn_pulse, note_onehot, note_multi, len_onehot, sw_level
  );

endinterface

// File: rtl/key_conditioner_debounce_cell.sv
// Purpose: 2-flop synchronizer plus stability counter for one asynchronous input.
// Latency: stable follows raw on the (DEBOUNCE_CYCLES+2)th edge after raw is first sampled.
// Backpressure: none; free-running level input and output.
module debounce_cell #(
  parameter int unsigned DEBOUNCE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable
);

  localparam int unsigned     CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      stable  <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
      // Any agreeing cycle restarts the count, so short glitches never land.
      if (sync_q2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync_q2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/key_conditioner.sv
// Purpose: debounces 20 front-panel inputs, makes press pulses, octave auto-repeat and one-hot key decode.
// Latency: levels and press pulses appear DEBOUNCE_CYCLES+2 edges after the raw change; decode is combinational.
// Backpressure: none; pulses are single-cycle and must be consumed when asserted.
module key_conditioner
  import key_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic             clk,
  input  logic             rst_n,
  key_conditioner_if.slave kc
);

  localparam int unsigned    REPEAT_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned    RCW         = (REPEAT_MAX > 1) ? $clog2(REPEAT_MAX) : 1;
  localparam logic [RCW-1:0] DELAY_LAST  = RCW'(REPEAT_DELAY - 1);
  localparam logic [RCW-1:0] PERIOD_LAST = RCW'(REPEAT_PERIOD - 1);

  logic [NUM_CHANNELS-1:0] raw_all;
  logic [NUM_CHANNELS-1:0] stable_all;

  assign raw_all = {kc.raw_sw, kc.raw_len, kc.raw_note, kc.raw_btn};

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (raw_all[g]),
      .stable(stable_all[g])
    );
  end

  logic [BTN_BITS-1:0]        btn_stable;
  logic [BTN_BITS-1:0]        btn_prev;
  logic [BTN_BITS-1:0]        btn_rise;
  logic [BTN_BITS-1:0]        press;
  logic [BTN_BITS-1:0]        pulse_out;
  logic [NOTE_KEY_BITS-1:0]   note_stable;
  logic [LENGTH_KEY_BITS-1:0] len_stable;
  logic [SW_BITS-1:0]         sw_stable;
  logic [3:0]                 note_ones;
  logic [3:0]                 len_ones;

  assign btn_stable  = stable_all[BTN_BITS-1:0];
  assign note_stable = stable_all[BTN_BITS +: NOTE_KEY_BITS];
  assign len_stable  = stable_all[BTN_BITS + NOTE_KEY_BITS +: LENGTH_KEY_BITS];
  assign sw_stable   = stable_all[NUM_CHANNELS-1 -: SW_BITS];

  always_comb begin
    btn_rise = btn_stable & ~btn_prev;
    press    = btn_rise;
    // Cancel wins over a submit that rises in the same cycle.
    if (btn_rise[BTN_CANCEL]) begin
      press[BTN_SUBMIT] = 1'b0;
    end
  end

  // Index 0 tracks oct_up, index 1 tracks oct_down.
  logic [1:0]     oct_lvl;
  logic [1:0]     oct_press;
  logic [1:0]     rep_fire;
  logic           both_held;
  logic [1:0]     rep_state [2];
  logic [RCW-1:0] rep_cnt   [2];

  assign oct_lvl   = {btn_stable[BTN_OCT_DOWN], btn_stable[BTN_OCT_UP]};
  assign oct_press = {press[BTN_OCT_DOWN], press[BTN_OCT_UP]};
  assign both_held = &oct_lvl;

  always_comb begin
    rep_fire = '0;
    for (int j = 0; j < 2; j++) begin
      rep_fire[j] = oct_lvl[j] && !both_held &&
                    (((rep_state[j] == RPT_DELAY)  && (rep_cnt[j] == DELAY_LAST)) ||
                     ((rep_state[j] == RPT_REPEAT) && (rep_cnt[j] == PERIOD_LAST)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_prev <= '0;
      for (int j = 0; j < 2; j++) begin
        rep_state[j] <= RPT_IDLE;
        rep_cnt[j]   <= '0;
      end
    end else begin
      btn_prev <= btn_stable;
      for (int j = 0; j < 2; j++) begin
        if (!oct_lvl[j] || both_held) begin
          rep_state[j] <= RPT_IDLE;
          rep_cnt[j]   <= '0;
        end else begin
          case (rep_state[j])
            RPT_IDLE: begin
              if (oct_press[j]) begin
                rep_state[j] <= RPT_DELAY;
                rep_cnt[j]   <= '0;
              end
            end
            RPT_DELAY: begin
              if (rep_cnt[j] == DELAY_LAST) begin
                rep_state[j] <= RPT_REPEAT;
                rep_cnt[j]   <= '0;
              end else begin
                rep_cnt[j] <= rep_cnt[j] + RCW'(1);
              end
            end
            RPT_REPEAT: begin
              if (rep_cnt[j] == PERIOD_LAST) begin
                rep_cnt[j] <= '0;
              end else begin
                rep_cnt[j] <= rep_cnt[j] + RCW'(1);
              end
            end
            default: begin
              rep_state[j] <= RPT_IDLE;
              rep_cnt[j]   <= '0;
            end
          endcase
        end
      end
    end
  end

  always_comb begin
    pulse_out               = press;
    pulse_out[BTN_OCT_UP]   = press[BTN_OCT_UP]   | rep_fire[0];
    pulse_out[BTN_OCT_DOWN] = press[BTN_OCT_DOWN] | rep_fire[1];
  end

  assign note_ones = count_ones(8'(note_stable));
  assign len_ones  = count_ones(8'(len_stable));

  assign kc.btn_level   = btn_stable;
  assign kc.btn_pulse   = pulse_out;
  assign kc.note_onehot = (note_ones == 4'd1) ? note_stable : '0;
  assign kc.note_multi  = (note_ones > 4'd1);
  assign kc.len_onehot  = (len_ones == 4'd1) ? len_stable : '0;
  assign kc.sw_level    = {sw_stable[SW_IS_RW], sw_stable[SW_RESET]};

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with short timing (debounce 4, delay 10, period 3).
module tb_key_conditioner;

  localparam int unsigned DC = 4;
  localparam int unsigned RD = 10;
  localparam int unsigned RP = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   errors  = 0;

  key_conditioner_if kif();

  key_conditioner #(
    .DEBOUNCE_CYCLES(DC),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .kc   (kif)
  );

  always #5 clk = ~clk;

  // Returns just after a rising edge, where outputs are sampled and inputs changed.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    kif.raw_btn  = '0;
    kif.raw_note = '0;
    kif.raw_len  = '0;
    kif.raw_sw   = '0;
    repeat (3) step();
    vectors++; if (kif.btn_level !== 4'b0000) begin errors++; $display("FAIL reset_btn_level got %b expected 0000", kif.btn_level); end
    vectors++; if (kif.btn_pulse !== 4'b0000) begin errors++; $display("FAIL reset_btn_pulse got %b expected 0000", kif.btn_pulse); end
    vectors++; if (kif.note_onehot !== 7'd0) begin errors++; $display("FAIL reset_note_onehot got %b expected 0", kif.note_onehot); end
    vectors++; if (kif.note_multi !== 1'b0) begin errors++; $display("FAIL reset_note_multi got %b expected 0", kif.note_multi); end
    vectors++; if (kif.len_onehot !== 7'd0) begin errors++; $display("FAIL reset_len_onehot got %b expected 0", kif.len_onehot); end
    vectors++; if (kif.sw_level !== 2'b00) begin errors++; $display("FAIL reset_sw_level got %b expected 00", kif.sw_level); end
    rst_n = 1'b1;
    repeat (8) step();
  endtask

  task automatic test_press();
    logic [3:0] exp_l;
    logic [3:0] exp_p;
    kif.raw_btn = 4'b0001;
    for (int k = 1; k <= 12; k++) begin
      step();
      exp_l = (k >= 6) ? 4'b0001 : 4'b0000;
      exp_p = (k == 6) ? 4'b0001 : 4'b0000;
      vectors++; if (kif.btn_level !== exp_l) begin errors++; $display("FAIL press_level edge %0d got %b expected %b", k, kif.btn_level, exp_l); end
      vectors++; if (kif.btn_pulse !== exp_p) begin errors++; $display("FAIL press_pulse edge %0d got %b expected %b", k, kif.btn_pulse, exp_p); end
    end
    kif.raw_btn = 4'b0000;
    for (int k = 1; k <= 8; k++) begin
      step();
      exp_l = (k < 6) ? 4'b0001 : 4'b0000;
      vectors++; if (kif.btn_level !== exp_l) begin errors++; $display("FAIL release_level edge %0d got %b expected %b", k, kif.btn_level, exp_l); end
      vectors++; if (kif.btn_pulse !== 4'b0000) begin errors++; $display("FAIL release_pulse edge %0d got %b expected 0000", k, kif.btn_pulse); end
    end
  endtask

  task automatic test_glitch();
    logic [11:0] pat;
    logic [3:0]  exp_l;
    logic [3:0]  exp_p;
    pat = 12'b0101_0101_0111;
    for (int i = 0; i < 12; i++) begin
      kif.raw_btn = {3'b000, pat[i]};
      step();
      vectors++; if (kif.btn_level !== 4'b0000) begin errors++; $display("FAIL glitch_level step %0d got %b expected 0000", i, kif.btn_level); end
      vectors++; if (kif.btn_pulse !== 4'b0000) begin errors++; $display("FAIL glitch_pulse step %0d got %b expected 0000", i, kif.btn_pulse); end
    end
    kif.raw_btn = 4'b0001;
    for (int k = 1; k <= 7; k++) begin
      step();
      exp_l = (k >= 6) ? 4'b0001 : 4'b0000;
      exp_p = (k == 6) ? 4'b0001 : 4'b0000;
      vectors++; if (kif.btn_level !== exp_l) begin errors++; $display("FAIL steady_level edge %0d got %b expected %b", k, kif.btn_level, exp_l); end
      vectors++; if (kif.btn_pulse !== exp_p) begin errors++; $display("FAIL steady_pulse edge %0d got %b expected %b", k, kif.btn_pulse, exp_p); end
    end
    kif.raw_btn = 4'b0000;
    repeat (8) step();
  endtask

  task automatic test_cancel_submit();
    logic [3:0] exp_l;
    logic [3:0] exp_p;
    kif.raw_btn = 4'b0011;
    for (int k = 1; k <= 7; k++) begin
      step();
      exp_l = (k >= 6) ? 4'b0011 : 4'b0000;
      exp_p = (k == 6) ? 4'b0010 : 4'b0000;
      vectors++; if (kif.btn_level !== exp_l) begin errors++; $display("FAIL cancel_level edge %0d got %b expected %b", k, kif.btn_level, exp_l); end
      vectors++; if (kif.btn_pulse !== exp_p) begin errors++; $display("FAIL cancel_pulse edge %0d got %b expected %b", k, kif.btn_pulse, exp_p); end
    end
    kif.raw_btn = 4'b0000;
    repeat (8) step();
  endtask

  task automatic test_repeat();
    logic [3:0] exp_l;
    logic [3:0] exp_p;
    kif.raw_btn = 4'b0100;
    for (int k = 1; k <= 45; k++) begin
      if (k == 31) kif.raw_btn = 4'b0000;
      step();
      exp_l = (k >= 6 && k <= 35) ? 4'b0100 : 4'b0000;
      exp_p = (k == 6 || (k >= 16 && k <= 35 && ((k - 16) % 3) == 0)) ? 4'b0100 : 4'b0000;
      vectors++; if (kif.btn_level !== exp_l) begin errors++; $display("FAIL repeat_level edge %0d got %b expected %b", k, kif.btn_level, exp_l); end
      vectors++; if (kif.btn_pulse !== exp_p) begin errors++; $display("FAIL repeat_pulse edge %0d got %b expected %b", k, kif.btn_pulse, exp_p); end
    end
  endtask

  task automatic test_both_held();
    logic [3:0] exp_p;
    kif.raw_btn = 4'b1100;
    for (int k = 1; k <= 30; k++) begin
      step();
      exp_p = (k == 6) ? 4'b1100 : 4'b0000;
      vectors++; if (kif.btn_pulse !== exp_p) begin errors++; $display("FAIL both_held_pulse edge %0d got %b expected %b", k, kif.btn_pulse, exp_p); end
    end
    kif.raw_btn = 4'b0000;
    repeat (8) step();
  endtask

  task automatic test_note();
    logic [6:0] exp_n;
    logic       exp_m;
    logic [6:0] exp_len;
    logic [1:0] exp_sw;
    kif.raw_note = 7'b0000101;
    kif.raw_len  = 7'b0100000;
    kif.raw_sw   = 2'b10;
    for (int k = 1; k <= 7; k++) begin
      step();
      exp_m   = (k >= 6);
      exp_len = (k >= 6) ? 7'b0100000 : 7'b0000000;
      exp_sw  = (k >= 6) ? 2'b10 : 2'b00;
      vectors++; if (kif.note_onehot !== 7'b0000000) begin errors++; $display("FAIL multi_onehot edge %0d got %b expected 0000000", k, kif.note_onehot); end
      vectors++; if (kif.note_multi !== exp_m) begin errors++; $display("FAIL multi_flag edge %0d got %b expected %b", k, kif.note_multi, exp_m); end
      vectors++; if (kif.len_onehot !== exp_len) begin errors++; $display("FAIL len_onehot edge %0d got %b expected %b", k, kif.len_onehot, exp_len); end
      vectors++; if (kif.sw_level !== exp_sw) begin errors++; $display("FAIL sw_level edge %0d got %b expected %b", k, kif.sw_level, exp_sw); end
    end
    kif.raw_note = 7'b0000100;
    for (int k = 1; k <= 7; k++) begin
      step();
      exp_m = (k < 6);
      exp_n = (k >= 6) ? 7'b0000100 : 7'b0000000;
      vectors++; if (kif.note_onehot !== exp_n) begin errors++; $display("FAIL single_onehot edge %0d got %b expected %b", k, kif.note_onehot, exp_n); end
      vectors++; if (kif.note_multi !== exp_m) begin errors++; $display("FAIL single_multi edge %0d got %b expected %b", k, kif.note_multi, exp_m); end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp_l;
    logic [3:0] exp_p;
    logic [1:0] exp_sw;
    kif.raw_btn = 4'b0001;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    vectors++; if (kif.sw_level !== 2'b00) begin errors++; $display("FAIL midreset_sw got %b expected 00", kif.sw_level); end
    vectors++; if (kif.note_onehot !== 7'd0) begin errors++; $display("FAIL midreset_note got %b expected 0", kif.note_onehot); end
    vectors++; if (kif.len_onehot !== 7'd0) begin errors++; $display("FAIL midreset_len got %b expected 0", kif.len_onehot); end
    vectors++; if (kif.btn_level !== 4'b0000) begin errors++; $display("FAIL midreset_btn got %b expected 0000", kif.btn_level); end
    repeat (2) step();
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      exp_l  = (k >= 6) ? 4'b0001 : 4'b0000;
      exp_p  = (k == 6) ? 4'b0001 : 4'b0000;
      exp_sw = (k >= 6) ? 2'b10 : 2'b00;
      vectors++; if (kif.btn_level !== exp_l) begin errors++; $display("FAIL postreset_level edge %0d got %b expected %b", k, kif.btn_level, exp_l); end
      vectors++; if (kif.btn_pulse !== exp_p) begin errors++; $display("FAIL postreset_pulse edge %0d got %b expected %b", k, kif.btn_pulse, exp_p); end
      vectors++; if (kif.sw_level !== exp_sw) begin errors++; $display("FAIL postreset_sw edge %0d got %b expected %b", k, kif.sw_level, exp_sw); end
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_glitch();
    test_cancel_submit();
    test_repeat();
    test_both_held();
    test_note();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 2_000_000, gives stable-input time in clk cycles (20 ms at 100 MHz); minimum 2.
REQ-002 Parameter REPEAT_DELAY, default 50_000_000, gives the hold time before octave auto-repeat starts (500 ms).
REQ-003 Parameter REPEAT_PERIOD, default 20_000_000, gives the auto-repeat pulse interval (200 ms).
REQ-004 clk  input  1  system clock, 100 MHz.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 raw_btn  input  4  raw push buttons {oct_down, oct_up, cancel, submit}, asynchronous.
REQ-007 raw_note  input  NOTE_KEY_BITS(7)  raw note switches, asynchronous.
REQ-008 raw_len  input  LENGTH_KEY_BITS(7)  raw length switches, asynchronous.
REQ-009 raw_sw  input  2  raw {is_rw, reset} slide switches, asynchronous.
REQ-010 btn_level  output  4  debounced button levels.
REQ-011 btn_pulse  output  4  one-cycle press pulses (bit order as raw_btn).
REQ-012 note_onehot  output  7  debounced note keys when exactly one is set, else 0.
REQ-013 note_multi  output  1  high while two or more debounced note keys are set.
REQ-014 len_onehot  output  7  debounced length keys when exactly one is set, else 0.
REQ-015 sw_level  output  2  debounced {is_rw, reset}.

Function
REQ-016 Each of the 20 raw channels passes through a 2-flop synchronizer before any other logic.
REQ-017 Per channel: while synced != stable, the counter increments; at count DEBOUNCE_CYCLES-1, stable takes the synced value and the counter clears.
REQ-018 Per channel: any cycle with synced == stable clears the counter, so a glitch shorter than DEBOUNCE_CYCLES cycles produces no output change.
REQ-019 Latency: stable changes on the (DEBOUNCE_CYCLES+2)th rising edge, counting as edge 1 the edge that first samples the new raw value; release timing is symmetric.
REQ-020 btn_pulse[i] is high for exactly one cycle, in the same cycle that btn_level[i] rises; a release never produces a pulse.
REQ-021 Simultaneous rising cancel and submit in one cycle: the cancel pulse is emitted and the submit pulse is suppressed.
REQ-022 Octave auto-repeat: while oct_up (or oct_down) is held, after REPEAT_DELAY cycles measured from the press pulse, an extra pulse fires, then one every REPEAT_PERIOD cycles until release.
REQ-023 Each octave button has a repeat FSM with states IDLE -> DELAY (on press pulse) -> REPEAT (delay expiry); release in any state returns it to IDLE with its counter cleared.
REQ-024 oct_up and oct_down both held: both repeat FSMs return to IDLE, and no repeat pulses fire until one of them is released and pressed again.
REQ-025 note_onehot and len_onehot are combinational from the registered stable vectors; the one-hot check uses a population count of exactly 1.
REQ-026 Debounce counter width is ceil(log2(DEBOUNCE_CYCLES)); repeat counter width is ceil(log2(max(REPEAT_DELAY, REPEAT_PERIOD))); counters never wrap.

Reset
REQ-027 Asserting rst_n low clears all synchronizers, stable values, counters and FSMs to 0/IDLE immediately.
REQ-028 Reset values: btn_level=0, btn_pulse=0, note_onehot=0, note_multi=0, len_onehot=0, sw_level=0.
REQ-029 Inputs already high at deassertion are reported as a new press after full debounce latency, with a pulse.
REQ-030 Reset asserted mid-debounce or mid-repeat discards the partial count.

Structure
REQ-031 NOTE_KEY_BITS, LENGTH_KEY_BITS, button bit indices and default timing constants live in the shared constants header.
REQ-032 One sub-module, debounce_cell (synchronizer + counter + stable register, parameterised by DEBOUNCE_CYCLES), is instantiated 20 times via generate.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-033 Set raw_btn[0]=1 and hold -> btn_level[0] and a single btn_pulse[0] appear on edge 6; no further pulses.
REQ-034 Apply a raw_btn[0] 3-cycle glitch, then bounce 1/0/1 every cycle for 8 cycles, then a steady 1 -> no output until 6 edges after the steady 1 begins.
REQ-035 Hold oct_up for 30 cycles -> pulses at press, +10, +13, +16, ...; release -> no pulses after the debounced release.
REQ-036 raw_note=0000101 -> note_onehot=0, note_multi=1; change to 0000100 -> note_onehot=0000100, note_multi=0 after debounce.
REQ-037 Raise cancel and submit on the same cycle -> only btn_pulse[1] fires.
REQ-038 Assert rst_n low at count 2 of a debounce -> outputs 0 immediately; after release with the input still 1 -> pulse 6 edges later.
